// File: rtl/ysyx_25020037_wbu_pkg.sv
// ysyx_25020037_wbu_pkg: shared widths, CSR bit positions, FSM encoding and bus layouts for the write-back unit
`ifndef YSYX_25020037_WBU_PKG_SV
`define YSYX_25020037_WBU_PKG_SV
`define YSYX_25020037_LSU_WBU_W (4 * 32 + 4 + 1 + 4 + 3)
`define YSYX_25020037_WBU_RF_W  (3 * 32 + 4 + 1 + 4 + 3)
package ysyx_25020037_wbu_pkg;
    localparam int XLEN        = 32;
    localparam int RIDX_W      = 4;
    localparam int CSR_MTVEC   = 3;
    localparam int CSR_MEPC    = 2;
    localparam int CSR_MSTATUS = 1;
    localparam int CSR_MCAUSE  = 0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT   = 2'd1,
        S_REDIRECT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   dnpc;
        logic [RIDX_W-1:0] rd;
        logic              gpr_wen;
        logic [XLEN-1:0]   gpr_wdata;
        logic [3:0]        csr_wen;
        logic [XLEN-1:0]   csr_wdata;
        logic              ecall;
        logic              mret;
        logic              ebreak;
    } wb_t;
endpackage
`endif

// File: rtl/ysyx_25020037_wbu_perf.sv
// ysyx_25020037_wbu_perf: retired-instruction counter and saturating redirect-stall counter
module ysyx_25020037_wbu_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit,
    input  logic        stall,
    output logic [63:0] minstret,
    output logic [31:0] stall_cycles
);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            minstret     <= '0;
            stall_cycles <= '0;
        end else begin
            if (commit) minstret <= minstret + 64'd1;
            if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
        end
endmodule

// File: rtl/ysyx_25020037_wbu.sv
// ysyx_25020037_wbu: write-back stage, commits one instruction then hands the next PC to the IFU
// Optional perf counters enabled by defining YSYX_25020037_WBU_PERF_EN.
module ysyx_25020037_wbu
    import ysyx_25020037_wbu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_dnpc,
    input  logic [RIDX_W-1:0] in_rd,
    input  logic              in_gpr_wen,
    input  logic [XLEN-1:0]   in_gpr_wdata,
    input  logic [3:0]        in_csr_wen,
    input  logic [XLEN-1:0]   in_csr_wdata,
    input  logic              in_ecall,
    input  logic              in_mret,
    input  logic              in_ebreak,
    output logic              wbu_valid,
    output logic              gpr_wen,
    output logic [RIDX_W-1:0] rd,
    output logic [XLEN-1:0]   gpr_wdata,
    output logic [3:0]        csr_wen,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              ecall_en,
    output logic              mret_en,
    output logic [XLEN-1:0]   commit_pc,
    output logic              npc_valid,
    output logic [XLEN-1:0]   npc,
    input  logic              npc_ready,
    output logic              halt
`ifdef YSYX_25020037_WBU_PERF_EN
    ,
    output logic [63:0]       minstret,
    output logic [31:0]       stall_cycles
`endif
);
    state_t state, state_n;
    wb_t    wb_q, wb_in;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_IDLE;
            wb_q  <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && lsu_valid) wb_q <= wb_in;
        end

    // Trap instructions own the CSR port, so explicit CSR writes are dropped for them.
    always_comb begin
        wb_in.pc        = in_pc;
        wb_in.dnpc      = in_dnpc;
        wb_in.rd        = in_rd;
        wb_in.gpr_wen   = in_gpr_wen && in_rd != '0;
        wb_in.gpr_wdata = in_gpr_wdata;
        wb_in.csr_wen   = (in_ecall || in_mret) ? 4'b0 : in_csr_wen;
        wb_in.csr_wdata = in_csr_wdata;
        wb_in.ecall     = in_ecall;
        wb_in.mret      = in_mret && !in_ecall;
        wb_in.ebreak    = in_ebreak;
    end

    always_comb begin
        state_n   = state;
        lsu_ready = state == S_IDLE;
        wbu_valid = state == S_COMMIT;
        npc_valid = state == S_COMMIT || state == S_REDIRECT;
        halt      = state == S_HALT;
        gpr_wen   = wb_q.gpr_wen && wbu_valid;
        csr_wen   = wbu_valid ? wb_q.csr_wen : 4'b0;
        ecall_en  = wb_q.ecall && wbu_valid;
        mret_en   = wb_q.mret && wbu_valid;
        rd        = wb_q.rd;
        gpr_wdata = wb_q.gpr_wdata;
        csr_wdata = wb_q.csr_wdata;
        commit_pc = wb_q.pc;
        npc       = wb_q.dnpc;
        state_n   = (state == S_IDLE && lsu_valid)      ? S_COMMIT :
                    (state == S_COMMIT)                 ? (wb_q.ebreak ? S_HALT : npc_ready ? S_IDLE : S_REDIRECT) :
                    (state == S_REDIRECT && npc_ready)  ? S_IDLE : state;
    end

`ifdef YSYX_25020037_WBU_PERF_EN
    ysyx_25020037_wbu_perf u_perf (
        .clk          (clk),
        .rst          (rst),
        .commit       (wbu_valid),
        .stall        (state == S_REDIRECT),
        .minstret     (minstret),
        .stall_cycles (stall_cycles)
    );
`endif
endmodule

// File: tb/tb_ysyx_25020037_wbu.sv
// tb_ysyx_25020037_wbu: table-driven and randomized checks of the write-back unit against a rule-level model
module tb_ysyx_25020037_wbu;
    logic        clk = 1'b0, rst = 1'b1;
    logic        lsu_valid = 1'b0, lsu_ready;
    logic [31:0] in_pc = '0, in_dnpc = '0, in_gpr_wdata = '0, in_csr_wdata = '0;
    logic [3:0]  in_rd = '0, in_csr_wen = '0;
    logic        in_gpr_wen = 1'b0, in_ecall = 1'b0, in_mret = 1'b0, in_ebreak = 1'b0;
    logic        wbu_valid, gpr_wen, ecall_en, mret_en, npc_valid, halt;
    logic        npc_ready = 1'b0;
    logic [3:0]  rd, csr_wen;
    logic [31:0] gpr_wdata, csr_wdata, commit_pc, npc;
`ifdef YSYX_25020037_WBU_PERF_EN
    logic [63:0] minstret;
    logic [31:0] stall_cycles;
`endif

    int     tests = 0, fails = 0;
    longint n_commit = 0, n_stall = 0;

    always #5 clk = ~clk;

    ysyx_25020037_wbu dut (
        .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .in_pc(in_pc), .in_dnpc(in_dnpc), .in_rd(in_rd), .in_gpr_wen(in_gpr_wen),
        .in_gpr_wdata(in_gpr_wdata), .in_csr_wen(in_csr_wen), .in_csr_wdata(in_csr_wdata),
        .in_ecall(in_ecall), .in_mret(in_mret), .in_ebreak(in_ebreak),
        .wbu_valid(wbu_valid), .gpr_wen(gpr_wen), .rd(rd), .gpr_wdata(gpr_wdata),
        .csr_wen(csr_wen), .csr_wdata(csr_wdata), .ecall_en(ecall_en), .mret_en(mret_en),
        .commit_pc(commit_pc), .npc_valid(npc_valid), .npc(npc), .npc_ready(npc_ready),
        .halt(halt)
`ifdef YSYX_25020037_WBU_PERF_EN
        , .minstret(minstret), .stall_cycles(stall_cycles)
`endif
    );

    typedef struct {
        logic [31:0] pc, dnpc, gd, cd;
        logic [3:0]  rd, cw;
        logic        gw, ec, mr, eb;
        logic        e_gw, e_ec, e_mr;
        logic [3:0]  e_cw;
        int          k;
    } vec_t;

    function automatic vec_t mk(logic [31:0] pc, logic [31:0] dnpc, logic [3:0] rd_i, logic gw,
                                logic [31:0] gd, logic [3:0] cw, logic [31:0] cd, logic ec,
                                logic mr, logic e_gw, logic [3:0] e_cw, logic e_ec, logic e_mr, int k);
        vec_t v;
        v.pc = pc; v.dnpc = dnpc; v.rd = rd_i; v.gw = gw; v.gd = gd; v.cw = cw; v.cd = cd;
        v.ec = ec; v.mr = mr; v.eb = 1'b0;
        v.e_gw = e_gw; v.e_cw = e_cw; v.e_ec = e_ec; v.e_mr = e_mr; v.k = k;
        return v;
    endfunction

    // Expected write enables straight from the architectural rules of the commit.
    function automatic vec_t model(vec_t v);
        bit trap;
        trap   = v.ec || v.mr;
        v.e_gw = v.gw && (v.rd != 0);
        v.e_ec = v.ec;
        v.e_mr = v.mr && !v.ec;
        v.e_cw = trap ? 4'd0 : v.cw;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        in_pc = v.pc; in_dnpc = v.dnpc; in_rd = v.rd; in_gpr_wen = v.gw; in_gpr_wdata = v.gd;
        in_csr_wen = v.cw; in_csr_wdata = v.cd; in_ecall = v.ec; in_mret = v.mr; in_ebreak = v.eb;
        lsu_valid = 1'b1;
    endtask

    task automatic scramble();
        in_pc = $urandom; in_dnpc = $urandom; in_rd = 4'($urandom); in_gpr_wen = 1'($urandom);
        in_gpr_wdata = $urandom; in_csr_wen = 4'($urandom); in_csr_wdata = $urandom;
        in_ecall = 1'($urandom); in_mret = 1'($urandom); in_ebreak = 1'($urandom);
    endtask

    // Starts at a negedge with the unit idle; ends at a negedge with the unit idle again.
    task automatic run(vec_t v, string nm);
        drive(v);
        npc_ready = (v.k == 0);
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        scramble();
        @(negedge clk);
        n_commit++;
        chk({nm, ".wbu_valid"}, 64'(wbu_valid), 1);
        chk({nm, ".gpr_wen"}, 64'(gpr_wen), 64'(v.e_gw));
        chk({nm, ".rd"}, 64'(rd), 64'(v.rd));
        chk({nm, ".gpr_wdata"}, 64'(gpr_wdata), 64'(v.gd));
        chk({nm, ".csr_wen"}, 64'(csr_wen), 64'(v.e_cw));
        chk({nm, ".csr_wdata"}, 64'(csr_wdata), 64'(v.cd));
        chk({nm, ".ecall_en"}, 64'(ecall_en), 64'(v.e_ec));
        chk({nm, ".mret_en"}, 64'(mret_en), 64'(v.e_mr));
        chk({nm, ".commit_pc"}, 64'(commit_pc), 64'(v.pc));
        chk({nm, ".npc_valid"}, 64'(npc_valid), 1);
        chk({nm, ".npc"}, 64'(npc), 64'(v.dnpc));
        chk({nm, ".lsu_ready_c"}, 64'(lsu_ready), 0);
        for (int j = 1; j <= v.k; j++) begin
            @(posedge clk); #1;
            npc_ready = (j == v.k);
            @(negedge clk);
            n_stall++;
            chk({nm, ".redir_wbu_valid"}, 64'(wbu_valid), 0);
            chk({nm, ".redir_npc_valid"}, 64'(npc_valid), 1);
            chk({nm, ".redir_npc"}, 64'(npc), 64'(v.dnpc));
            chk({nm, ".redir_lsu_ready"}, 64'(lsu_ready), 0);
            chk({nm, ".redir_wens"}, 64'({gpr_wen, csr_wen, ecall_en, mret_en}), 0);
            chk({nm, ".redir_gpr_wdata"}, 64'(gpr_wdata), 64'(v.gd));
        end
        @(posedge clk); #1;
        npc_ready = 1'b0;
        @(negedge clk);
        chk({nm, ".idle_lsu_ready"}, 64'(lsu_ready), 1);
        chk({nm, ".idle_npc_valid"}, 64'(npc_valid), 0);
        chk({nm, ".idle_wbu_valid"}, 64'(wbu_valid), 0);
    endtask

    vec_t tbl[9];
    vec_t v;

    initial begin
        tbl[0] = mk(32'h80000000, 32'h80000004, 4'd5, 1, 32'h1234, 4'b0000, 32'h0, 0, 0, 1, 4'b0000, 0, 0, 0);
        tbl[1] = mk(32'h80000004, 32'h80000008, 4'd0, 1, 32'hdead, 4'b0000, 32'h0, 0, 0, 0, 4'b0000, 0, 0, 0);
        tbl[2] = mk(32'h80000010, 32'h80001000, 4'd0, 0, 32'h0, 4'b0100, 32'h55, 1, 0, 0, 4'b0000, 1, 0, 0);
        tbl[3] = mk(32'h80001020, 32'h80000014, 4'd2, 0, 32'h0, 4'b0001, 32'h77, 0, 1, 0, 4'b0000, 0, 1, 1);
        tbl[4] = mk(32'h80000020, 32'h80001000, 4'd0, 0, 32'h0, 4'b1000, 32'h99, 1, 1, 0, 4'b0000, 1, 0, 0);
        tbl[5] = mk(32'h80000024, 32'h80000028, 4'd1, 0, 32'h0, 4'b1000, 32'h80001000, 0, 0, 0, 4'b1000, 0, 0, 2);
        tbl[6] = mk(32'h80000028, 32'h8000002c, 4'd3, 0, 32'h0, 4'b0110, 32'habcd, 0, 0, 0, 4'b0110, 0, 0, 0);
        tbl[7] = mk(32'h8000002c, 32'h80000030, 4'd9, 0, 32'h5555, 4'b0000, 32'h0, 0, 0, 0, 4'b0000, 0, 0, 1);
        tbl[8] = mk(32'h80000030, 32'h80000100, 4'd15, 1, 32'hcafe, 4'b0000, 32'h0, 0, 0, 1, 4'b0000, 0, 0, 3);

        @(negedge clk);
        chk("reset.lsu_ready", 64'(lsu_ready), 1);
        chk("reset.outs", 64'({wbu_valid, npc_valid, halt, gpr_wen, csr_wen}), 0);
        chk("reset.fields", 64'({npc, commit_pc}), 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) run(tbl[i], $sformatf("tbl%0d", i));

        // Asynchronous reset in the middle of a redirect wait.
        v = mk(32'h80000040, 32'h80000044, 4'd6, 1, 32'h42, 4'b0000, 32'h0, 0, 0, 1, 4'b0000, 0, 0, 0);
        drive(v);
        npc_ready = 1'b0;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst.lsu_ready", 64'(lsu_ready), 1);
        chk("arst.outs", 64'({wbu_valid, npc_valid, halt}), 0);
        chk("arst.npc", 64'(npc), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_commit = 0;
        n_stall = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("arst.no_write", 64'({wbu_valid, gpr_wen}), 0);
        end
`ifdef YSYX_25020037_WBU_PERF_EN
        chk("arst.minstret", minstret, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            v.pc = $urandom; v.dnpc = $urandom; v.rd = 4'($urandom); v.gw = 1'($urandom);
            v.gd = $urandom; v.cw = 4'($urandom); v.cd = $urandom;
            v.ec = ($urandom_range(0, 3) == 0); v.mr = ($urandom_range(0, 3) == 0); v.eb = 1'b0;
            v.k = $urandom_range(0, 3);
            v = model(v);
            run(v, $sformatf("rnd%0d", t));
        end

        v = mk(32'h80000050, 32'h80000054, 4'd4, 1, 32'h1111, 4'b0000, 32'h0, 0, 0, 1, 4'b0000, 0, 0, 0);
        run(v, "pre_ebreak");
        v = mk(32'h80000054, 32'h80000058, 4'd7, 1, 32'h2222, 4'b0000, 32'h0, 0, 0, 1, 4'b0000, 0, 0, 0);
        v.eb = 1'b1;
        drive(v);
        npc_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_commit++;
        chk("ebreak.wbu_valid", 64'(wbu_valid), 1);
        chk("ebreak.gpr_wen", 64'(gpr_wen), 1);
        chk("ebreak.rd", 64'(rd), 7);
        chk("ebreak.gpr_wdata", 64'(gpr_wdata), 32'h2222);
        chk("ebreak.halt_early", 64'(halt), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("halt.halt", 64'(halt), 1);
            chk("halt.lsu_ready", 64'(lsu_ready), 0);
            chk("halt.npc_valid", 64'(npc_valid), 0);
            chk("halt.wbu_valid", 64'(wbu_valid), 0);
        end
`ifdef YSYX_25020037_WBU_PERF_EN
        chk("perf.minstret", minstret, 64'(n_commit));
        chk("perf.stall_cycles", 64'(stall_cycles), 64'(n_stall));
`endif
        lsu_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
